// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Connects the memory pipeline stage to the external SRAM-like data bus,
//   which uses a req / addr_ok / data_ok handshake. The block issues at most one
//   transaction at a time. It stalls the pipeline until the transaction is
//   answered. While the pipeline is frozen, it holds the completed load result.
//   When an exception flush kills a transaction that is already on the bus, the
//   block waits for that transaction to drain.
//
// Build option:
//   DMEM_BYPASS_EN - if defined, a new request goes onto the bus in the same
//                    cycle it arrives from the memory stage (combinational
//                    path). If undefined, every bus output is driven from
//                    registers.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   mread_valid/addr/size             load request from memory stage
//   mwrite_valid/addr/data/strobe/size store request from memory stage
//   advance                           mem->wb register updates this cycle
//   flush                             exception/eret flush of memory stage
//   data_req/wr/size/addr/wstrb/wdata bus request channel
//   data_addr_ok, data_data_ok        bus handshake responses
//   data_rdata                        bus read data
//   rd                                load data to memory stage
//   stall                             pipeline freeze to hazard unit
module dmem_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mread_valid,
    input  logic [31:0] mread_addr,
    input  logic [1:0]  mread_size,
    input  logic        mwrite_valid,
    input  logic [31:0] mwrite_addr,
    input  logic [31:0] mwrite_data,
    input  logic [3:0]  mwrite_strobe,
    input  logic [1:0]  mwrite_size,
    input  logic        advance,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rd,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic        kill, kill_nx;
    logic        pend, accept;
    logic [31:0] rd_q;

    // request fields selected from whichever side is valid
    logic        in_wr;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [3:0]  in_wstrb;

    // latched request, held stable for the whole life of the transaction
    logic        q_wr;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_wstrb;

    assign pend     = mread_valid | mwrite_valid;
    assign accept   = (state == S_IDLE) && pend && !flush;
    assign in_wr    = mwrite_valid;
    assign in_size  = mwrite_valid ? mwrite_size   : mread_size;
    assign in_addr  = mwrite_valid ? mwrite_addr   : mread_addr;
    assign in_wstrb = mwrite_valid ? mwrite_strobe : 4'b0;
    assign in_wdata = mwrite_valid ? mwrite_data   : 32'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            kill    <= 1'b0;
            rd_q    <= 32'b0;
            q_wr    <= 1'b0;
            q_size  <= 2'b0;
            q_addr  <= 32'b0;
            q_wstrb <= 4'b0;
            q_wdata <= 32'b0;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            if (accept) begin
                q_wr    <= in_wr;
                q_size  <= in_size;
                q_addr  <= in_addr;
                q_wstrb <= in_wstrb;
                q_wdata <= in_wdata;
            end
            // a write ack also loads rd_q; the value is simply never used
            if (state == S_WAIT && data_data_ok)
                rd_q <= data_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        kill_nx  = kill;
        stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall = 1'b1;
`ifdef DMEM_BYPASS_EN
                    state_nx = data_addr_ok ? S_WAIT : S_REQ;
`else
                    state_nx = S_REQ;
`endif
                end
            end
            S_REQ: begin
                // A request cannot be withdrawn from the bus. On flush we only
                // mark it as killed and let it finish.
                stall = 1'b1;
                if (flush)
                    kill_nx = 1'b1;
                if (data_addr_ok)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    // A killed transaction keeps the pipeline stalled through
                    // its drain cycle, so the dead result is never consumed.
                    stall   = kill;
                    kill_nx = 1'b0;
                    if (kill || flush || advance)
                        state_nx = S_IDLE;
                    else
                        state_nx = S_HOLD;
                end else begin
                    stall = 1'b1;
                    if (flush)
                        kill_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (advance || flush)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        data_req   = (state == S_REQ);
        data_wr    = q_wr;
        data_size  = q_size;
        data_addr  = q_addr;
        data_wstrb = q_wstrb;
        data_wdata = q_wdata;
`ifdef DMEM_BYPASS_EN
        if (accept) begin
            data_req   = 1'b1;
            data_wr    = in_wr;
            data_size  = in_size;
            data_addr  = in_addr;
            data_wstrb = in_wstrb;
            data_wdata = in_wdata;
        end
`endif
    end

    assign rd = (state == S_WAIT && data_data_ok) ? data_rdata : rd_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Randomized bench for dmem_bridge. The bench plays two roles: the memory
//   stage and the bus slave. For every transaction the expected cycle in which
//   req, addr_ok and data_ok occur, the stall window and the returned data are
//   worked out arithmetically from the chosen response delays. Each cycle the
//   bench compares the DUT outputs against that timeline.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mread_valid, mwrite_valid, advance, flush;
    logic [31:0] mread_addr, mwrite_addr, mwrite_data;
    logic [1:0]  mread_size, mwrite_size;
    logic [3:0]  mwrite_strobe;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, rd;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok, stall;

`ifdef DMEM_BYPASS_EN
    localparam int R = 0;   // cycle offset of the first req relative to pend
`else
    localparam int R = 1;
`endif

    int total = 0;
    int bad   = 0;

    dmem_bridge dut (
        .clk(clk), .resetn(resetn),
        .mread_valid(mread_valid), .mread_addr(mread_addr), .mread_size(mread_size),
        .mwrite_valid(mwrite_valid), .mwrite_addr(mwrite_addr), .mwrite_data(mwrite_data),
        .mwrite_strobe(mwrite_strobe), .mwrite_size(mwrite_size),
        .advance(advance), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .rd(rd), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        mread_valid = 1'b0; mread_addr = '0; mread_size = '0;
        mwrite_valid = 1'b0; mwrite_addr = '0; mwrite_data = '0;
        mwrite_strobe = '0; mwrite_size = '0;
        advance = 1'b0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
        drive_idle();
        #3;
        chk("idle_stall", 72'(stall), 72'(0));
        chk("idle_req", 72'(data_req), 72'(0));
    endtask

    // a: cycles addr_ok is withheld after req appears
    // d: extra cycles between addr_ok and data_ok
    // h: cycles without advance after data_ok
    // kl: flush the instruction while its request is still on the bus
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] strb, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int a, input int d,
                           input int h, input bit kl);
        int A, D, E, F, pend_end, nstall, exp_stall_n;
        bit kill;
        logic [71:0] exp_f;
        kill = kl && (a > 0);
        A = R + a;
        D = A + 1 + d;
        F = kill ? R + 1 + int'($urandom_range(0, a - 1)) : -1;
        E = kill ? D : D + h;
        pend_end = kill ? F : E;
        exp_stall_n = kill ? D + 1 : D;
        exp_f = {wr, size, addr, wr ? strb : 4'h0, wr ? wdat : 32'h0};
        nstall = 0;
        for (int c = 0; c <= E; c++) begin
            @(posedge clk); #1;
            mread_valid   = !wr && (c <= pend_end);
            mwrite_valid  = wr && (c <= pend_end);
            mread_addr    = wr ? $urandom : addr;
            mread_size    = wr ? 2'($urandom_range(0, 3)) : size;
            mwrite_addr   = wr ? addr : $urandom;
            mwrite_size   = wr ? size : 2'($urandom_range(0, 3));
            mwrite_strobe = wr ? strb : 4'($urandom_range(1, 15));
            mwrite_data   = wr ? wdat : $urandom;
            flush         = (c == F);
            advance       = !kill && (c == E);
            #1;
            data_addr_ok = (c == A);
            data_data_ok = (c == D) || (!kill && c > D && $urandom_range(0, 1) == 1);
            data_rdata   = (c == D) ? rdat : $urandom;
            #2;
            chk("req", 72'(data_req), 72'(c >= R && c <= A));
            if (c >= R && c <= A)
                chk("fields", {data_wr, data_size, data_addr, data_wstrb,
                               data_wr ? data_wdata : 32'h0}, exp_f);
            chk("stall", 72'(stall), 72'(kill ? (c <= D) : (c < D)));
            if (stall) nstall++;
            if (!kill && !wr && c >= D)
                chk("rd", 72'(rd), 72'(rdat));
        end
        chk("stall_cycles", 72'(nstall), 72'(exp_stall_n));
    endtask

    initial begin
        bit given;
        drive_idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_bus", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata}, 72'(0));
        chk("rst_rd", 72'(rd), 72'(0));
        chk("rst_stall", 72'(stall), 72'(0));
        @(negedge clk) resetn = 1'b1;
        idle_cyc();

        // directed cases
        run_txn(0, 32'h8000_0010, 2'd2, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn(1, 32'h0000_1002, 2'd1, 4'b1100, 32'h1234_0000, 32'h0, 0, 0, 0, 0);
        run_txn(0, 32'h0000_0200, 2'd2, 4'h0, 32'h0, 32'hA5A5_0F0F, 3, 0, 0, 0);
        run_txn(0, 32'h0000_0104, 2'd2, 4'h0, 32'h0, 32'h0000_0055, 0, 0, 2, 0);
        run_txn(0, 32'h0000_0300, 2'd2, 4'h0, 32'h0, 32'hFFFF_0000, 2, 1, 0, 1);
        run_txn(0, 32'h0000_0304, 2'd2, 4'h0, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0);
        idle_cyc();

        // random traffic
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [1:0]  sz;
            logic [31:0] ad;
            logic [3:0]  sb;
            wr = ($urandom_range(0, 1) == 1);
            sz = 2'($urandom_range(0, 2));
            ad = $urandom;
            sb = 4'($urandom_range(1, 15));
            run_txn(wr, ad, sz, sb, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_cyc();
        end

        // reset while a load waits for data_ok, then a stray data_ok
        given = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive_idle();
            mread_valid = 1'b1;
            mread_addr  = 32'h0000_0400;
            mread_size  = 2'd2;
            #1;
            data_addr_ok = data_req && !given;
            given = given | data_addr_ok;
        end
        #2;
        chk("wait_stall", 72'(stall), 72'(1));
        #1;
        resetn = 1'b0;
        drive_idle();
        #1;
        chk("mid_rst_bus", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata}, 72'(0));
        chk("mid_rst_rd", 72'(rd), 72'(0));
        chk("mid_rst_stall", 72'(stall), 72'(0));
        @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        #3;
        chk("stray_rd", 72'(rd), 72'(0));
        chk("stray_stall", 72'(stall), 72'(0));
        chk("stray_req", 72'(data_req), 72'(0));
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        #3;
        chk("stray_rd_after", 72'(rd), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
